// File: rtl/dsp_isa_pkg.sv
// Opcodes, FSM states and instruction-field helpers
// shared by the accumulator DSP sequencer.
package dsp_isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_LDX  = 4'h4;
  localparam logic [3:0] OP_MAC  = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SAR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JNZ  = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    DONE
  } state_t;

  function automatic logic [3:0] opc(input logic [11:0] w);
    return w[11:8];
  endfunction

  function automatic logic [7:0] imm(input logic [11:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/dsp_acc_alu.sv
// Combinational execute unit: one instruction's effect
// on accumulator, X register and branch decision.
module dsp_acc_alu
  import dsp_isa_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [3:0]       opcode,
  input  logic [7:0]       imm_val,
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] x,
  output logic [ACC_W-1:0] acc_next,
  output logic [ACC_W-1:0] x_next,
  output logic             take_jump,
  output logic             illegal
);

  logic [ACC_W-1:0] sext;
  logic [ACC_W-1:0] zext;
  logic [ACC_W-1:0] prod;

  assign sext = {{(ACC_W-8){imm_val[7]}}, imm_val};
  assign zext = {{(ACC_W-8){1'b0}}, imm_val};
  // low half of a product is identical for signed and unsigned operands
  assign prod = x * sext;

  always_comb begin
    acc_next  = acc;
    x_next    = x;
    take_jump = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_LDI:  acc_next = sext;
      OP_ADDI: acc_next = acc + sext;
      OP_SUBI: acc_next = acc - sext;
      OP_LDX:  x_next = sext;
      OP_MAC:  acc_next = acc + prod;
      OP_ANDI: acc_next = acc & zext;
      OP_ORI:  acc_next = acc | zext;
      OP_SHL:  acc_next = acc << imm_val[3:0];
      OP_SAR:  acc_next = $signed(acc) >>> imm_val[3:0];
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = (acc == '0);
      OP_JNZ:  take_jump = (acc != '0);
      OP_ILLD: illegal = 1'b1;
      OP_ILLE: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/dsp_exec_core.sv
// Program sequencer: fetch/exec FSM, pc, watchdog and
// accumulator registers around dsp_acc_alu.
module dsp_exec_core
  import dsp_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FETCH_LAT = 2,
  parameter int MAX_STEPS = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [11:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ACC_W-1:0]  accumulator,
  output logic              data_ready,
  output logic              busy,
  output logic              fault
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int LAT_W  = $clog2(FETCH_LAT + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(FETCH_LAT - 1);
  localparam logic [STEP_W-1:0] WD_LAST  = STEP_W'(MAX_STEPS - 1);

  state_t state;
  state_t state_next;

  logic [ACC_W-1:0]  x;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  x_next;
  logic [STEP_W-1:0] steps;
  logic [LAT_W-1:0]  lat;
  logic              take_jump;
  logic              illegal;
  logic              is_halt;
  logic              wd_hit;
  logic              exec_go;

  dsp_acc_alu #(.ACC_W(ACC_W)) u_alu (
    .opcode    (opc(instr)),
    .imm_val   (imm(instr)),
    .acc       (accumulator),
    .x         (x),
    .acc_next  (acc_next),
    .x_next    (x_next),
    .take_jump (take_jump),
    .illegal   (illegal)
  );

  assign is_halt    = (opc(instr) == OP_HALT);
  assign wd_hit     = (steps == WD_LAST);
  assign exec_go    = (state == EXEC) && start;
  assign data_ready = (state == DONE);
  assign busy       = (state == FETCH) || (state == EXEC);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:
        if (start) state_next = FETCH;
      FETCH:
        if (!start) state_next = IDLE;
        else if (lat == LAT_LAST) state_next = EXEC;
      EXEC:
        if (!start) state_next = IDLE;
        else if (illegal || is_halt || wd_hit) state_next = DONE;
        else state_next = FETCH;
      DONE:
        if (!start) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      accumulator <= '0;
      x           <= '0;
      steps       <= '0;
      lat         <= '0;
      fault       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        pc          <= '0;
        accumulator <= '0;
        x           <= '0;
        steps       <= '0;
        lat         <= '0;
        fault       <= 1'b0;
      end
      if (state == FETCH && start)
        lat <= (lat == LAT_LAST) ? '0 : lat + LAT_W'(1);
      if (exec_go) begin
        steps <= steps + STEP_W'(1);
        if (illegal || wd_hit)
          fault <= 1'b1;
        if (!illegal) begin
          accumulator <= acc_next;
          x           <= x_next;
        end
        // HALT and illegal words leave pc on the stopping instruction
        if (!illegal && !is_halt)
          pc <= take_jump ? ADDR_W'(imm(instr)) : pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dsp_exec_core.sv
// Scoreboard bench: RAM + control-unit register model,
// directed programs with hand-computed results.
module tb_dsp_exec_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] instr = 12'h000;
  logic [7:0]  pc;
  logic [15:0] accumulator;
  logic        data_ready;
  logic        busy;
  logic        fault;

  dsp_exec_core dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instr       (instr),
    .pc          (pc),
    .accumulator (accumulator),
    .data_ready  (data_ready),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  logic [11:0] ram [256];
  logic [11:0] ram_q = 12'h000;

  // two-cycle fetch: RAM read register then control-unit register
  always @(posedge clk) begin
    ram_q <= ram[pc];
    instr <= ram_q;
  end

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  pc;
    logic        fault;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  logic dr_q = 1'b0;

  task automatic chk(input string n, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (data_ready && !dr_q) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ready: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        me = q.pop_front();
        chk({me.name, "_acc"}, int'(accumulator), int'(me.acc));
        chk({me.name, "_pc"}, int'(pc), int'(me.pc));
        chk({me.name, "_fault"}, int'(fault), int'(me.fault));
        chk({me.name, "_lat"}, cyc - t0, me.lat);
      end
    end
    dr_q = data_ready;
  end

  task automatic clear_ram();
    for (int i = 0; i < 256; i++) ram[i] = 12'hF00;
  endtask

  task automatic run(input string name, input logic [15:0] acc,
                     input logic [7:0] p, input logic f, input int n);
    int k;
    q.push_back('{acc, p, f, 3 * n, name});
    start = 1'b1;
    t0 = cyc + 1;
    k = 0;
    while (k < 4000 && !data_ready) begin
      @(negedge clk);
      k++;
    end
    if (!data_ready) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no data_ready expected ready", name);
      void'(q.pop_back());
    end else begin
      repeat (2) @(negedge clk);
      chk({name, "_hold"}, int'(data_ready), 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk({name, "_idle"}, int'({busy, data_ready}), 0);
  endtask

  initial begin
    clear_ram();
    repeat (2) @(negedge clk);
    chk("rst_acc", int'(accumulator), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_flags", int'({data_ready, busy, fault}), 0);
    reset = 1'b0;
    @(negedge clk);

    clear_ram();
    ram[0] = 12'h105; ram[1] = 12'h203;
    run("basic", 16'h0008, 8'd2, 1'b0, 3);

    clear_ram();
    ram[0] = 12'h1FE; ram[1] = 12'h403; ram[2] = 12'h504;
    run("mac", 16'h000A, 8'd3, 1'b0, 4);

    clear_ram();
    ram[0] = 12'h180; ram[1] = 12'h902;
    run("sar", 16'hFFE0, 8'd2, 1'b0, 3);

    clear_ram();
    ram[0] = 12'h103; ram[1] = 12'h301; ram[2] = 12'hC01;
    run("loop", 16'h0000, 8'd3, 1'b0, 8);

    clear_ram();
    ram[0] = 12'hD00;
    run("illegal", 16'h0000, 8'd0, 1'b1, 1);

    clear_ram();
    ram[0] = 12'hA00;
    run("watchdog", 16'h0000, 8'd0, 1'b1, 1023);

    clear_ram();
    ram[0] = 12'hBFF; ram[255] = 12'h201;
    run("wrap", 16'h0001, 8'd1, 1'b0, 4);

    clear_ram();
    ram[0] = 12'h105; ram[1] = 12'h203;
    start = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_acc", int'(accumulator), 5);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_acc", int'(accumulator), 0);
    chk("midrst_pc", int'(pc), 0);
    chk("midrst_flags", int'({data_ready, busy, fault}), 0);
    reset = 1'b0;
    @(negedge clk);

    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_flags", int'({data_ready, busy}), 0);
    chk("abort_acc", int'(accumulator), 5);
    chk("abort_pc", int'(pc), 1);
    repeat (2) @(negedge clk);

    clear_ram();
    ram[0] = 12'h203;
    run("rerun", 16'h0003, 8'd1, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
